// File: rtl/cpu_types_pkg.sv
// Shared CPU types: multiply/divide opcode encoding and small opcode helpers.
package cpu_types_pkg;

    typedef enum logic [1:0] {
        MD_MULT  = 2'd0,
        MD_MULTU = 2'd1,
        MD_DIV   = 2'd2,
        MD_DIVU  = 2'd3
    } muldiv_op_t;

    function automatic logic op_is_div(input muldiv_op_t op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic op_is_signed(input muldiv_op_t op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add multiply or restoring divide on a shared 2*WIDTH+1 accumulator.
module muldiv_step
    import cpu_types_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [2*WIDTH:0] acc_i,
    input  logic [WIDTH-1:0] opnd_i,
    input  muldiv_op_t       op_i,
    output logic [2*WIDTH:0] acc_o,
    output logic             q_bit_o
);

    logic [WIDTH:0]   mul_sum;
    logic [2*WIDTH:0] shl;
    logic [WIDTH+1:0] trial;

    // Multiply: {carry,hi} += multiplicand when lsb set, then shift right.
    // Divide: shift left, trial-subtract divisor from the upper half, keep if no borrow.
    always_comb begin
        mul_sum = acc_i[2*WIDTH:WIDTH] + (acc_i[0] ? {1'b0, opnd_i} : {(WIDTH+1){1'b0}});
        shl     = {acc_i[2*WIDTH-1:0], 1'b0};
        trial   = {1'b0, shl[2*WIDTH:WIDTH]} - {2'b00, opnd_i};
        acc_o   = {1'b0, mul_sum, acc_i[WIDTH-1:1]};
        q_bit_o = 1'b0;
        if (op_is_div(op_i)) begin
            q_bit_o = ~trial[WIDTH+1];
            acc_o   = trial[WIDTH+1] ? shl : {trial[WIDTH:0], shl[WIDTH-1:0]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative EX-stage multiply/divide unit owning the architectural HI/LO registers.
module muldiv_unit
    import cpu_types_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             start,
    input  muldiv_op_t       op,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    input  logic             hilo_read,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic             flush,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             stall_req
);

    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam int unsigned ACC_W = 2*WIDTH + 1;

    typedef enum logic [1:0] {MD_IDLE, MD_CALC, MD_FIX} md_state_t;

    md_state_t        state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    muldiv_op_t       op_q, op_d;
    logic             neg_res_q, neg_res_d;
    logic             neg_rem_q, neg_rem_d;
    logic             dz_q, dz_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic             done_q, done_d;

    logic [ACC_W-1:0]   step_acc;
    logic               step_q;
    logic [WIDTH-1:0]   rs_abs, rt_abs, quo, rem;
    logic [2*WIDTH-1:0] prod;

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .acc_i   (acc_q),
        .opnd_i  (opnd_q),
        .op_i    (op_q),
        .acc_o   (step_acc),
        .q_bit_o (step_q)
    );

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q   <= MD_IDLE;
            count_q   <= '0;
            acc_q     <= '0;
            opnd_q    <= '0;
            op_q      <= MD_MULT;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dz_q      <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            acc_q     <= acc_d;
            opnd_q    <= opnd_d;
            op_q      <= op_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            dz_q      <= dz_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        acc_d     = acc_q;
        opnd_d    = opnd_q;
        op_d      = op_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        dz_d      = dz_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;

        rs_abs = (op_is_signed(op) && rs_val[WIDTH-1]) ? -rs_val : rs_val;
        rt_abs = (op_is_signed(op) && rt_val[WIDTH-1]) ? -rt_val : rt_val;
        prod   = neg_res_q ? -acc_q[2*WIDTH-1:0] : acc_q[2*WIDTH-1:0];
        rem    = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
        // Divide-by-zero forces an all-ones quotient regardless of sign correction.
        quo    = dz_q ? '1 : (neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0]);

        case (state_q)
            MD_IDLE: begin
                if (!flush) begin
                    if (start) begin
                        acc_d     = {{(WIDTH+1){1'b0}}, rs_abs};
                        opnd_d    = rt_abs;
                        op_d      = op;
                        neg_res_d = op_is_signed(op) & (rs_val[WIDTH-1] ^ rt_val[WIDTH-1]);
                        neg_rem_d = (op == MD_DIV) & rs_val[WIDTH-1];
                        dz_d      = op_is_div(op) & (rt_val == '0);
                        count_d   = '0;
                        state_d   = MD_CALC;
                    end else begin
                        if (mthi) hi_d = rs_val;
                        if (mtlo) lo_d = rs_val;
                    end
                end
            end
            MD_CALC: begin
                if (flush) begin
                    state_d = MD_IDLE;
                end else begin
                    acc_d   = {step_acc[ACC_W-1:1], step_acc[0] | step_q};
                    count_d = count_q + CNT_W'(1);
                    if (count_q == CNT_W'(WIDTH-1)) state_d = MD_FIX;
                end
            end
            MD_FIX: begin
                state_d = MD_IDLE;
                if (!flush) begin
                    done_d = 1'b1;
                    if (op_is_div(op_q)) begin
                        hi_d = rem;
                        lo_d = quo;
                    end else begin
                        hi_d = prod[2*WIDTH-1:WIDTH];
                        lo_d = prod[WIDTH-1:0];
                    end
                end
            end
            default: state_d = MD_IDLE;
        endcase
    end

    assign hi        = hi_q;
    assign lo        = lo_q;
    assign done      = done_q;
    assign busy      = (state_q != MD_IDLE);
    assign stall_req = busy & (start | hilo_read | mthi | mtlo);

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multiply/divide unit in the EX stage, directly downstream of the ID/EX pipeline latch.
- Consumes the latched operands (rdat_one/rdat_two) and the decoded op, and computes MULT/MULTU/DIV/DIVU into architectural HI/LO registers.
- Drives a stall request back to the ID/EX latch and upstream stages while busy.
- Also services MTHI/MTLO writes; HI/LO are always readable for MFHI/MFLO.

Parameters:
- WIDTH, 32, operand width; HI/LO are WIDTH bits, iteration count = WIDTH.

Ports:
- CLK  in  1  clock, rising edge
- nRST  in  1  asynchronous active-low reset
- start  in  1  launch op this cycle (from ID/EX, instruction valid in EX)
- op  in  2  muldiv_op_t: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU
- rs_val  in  WIDTH  operand A / dividend (rdat_one path)
- rt_val  in  WIDTH  operand B / divisor (rdat_two path)
- hilo_read  in  1  EX instruction is MFHI/MFLO
- mthi  in  1  write rs_val to HI
- mtlo  in  1  write rs_val to LO
- flush  in  1  abort in-flight op (branch/jump squash)
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register
- busy  out  1  unit not idle
- done  out  1  one-cycle pulse: HI/LO just updated by a mult/div
- stall_req  out  1  hold ID/EX and upstream stages

Behaviour:
- Reset (async, nRST=0): state=IDLE; hi=0, lo=0, busy=0, done=0, count=0; all internal operand/accumulator registers=0. Reset mid-operation aborts the op; HI/LO return to 0.
- States:
  - IDLE: start=1 and flush=0 -> latch |rs|, |rt| (signed ops) or raw values (unsigned ops); latch result-sign flags and op; count=0; go to CALC.
  - CALC: one radix-2 step per cycle. Multiply is shift-add into a 2*WIDTH product. Divide is restoring: shift the remainder left by 1, subtract the divisor, keep the result if non-negative, set the quotient bit. count++; at count==WIDTH-1 go to FIX.
  - FIX: apply sign correction.
    - MULT: negate the 64-bit product if the operand signs differ.
    - DIV: quotient negated if the operand signs differ; remainder takes the dividend's sign.
    - Write HI/LO (mult: HI=product[63:32], LO=product[31:0]; div: LO=quotient, HI=remainder). Go to IDLE.
- done=1 for exactly the cycle after FIX; 0 otherwise.
- Latency: the edge accepting start is E0; CALC spans E1..E32; HI/LO update at E33; done high in the cycle following E33.
- busy = (state != IDLE), combinational from state.
- stall_req = busy & (start | hilo_read | mthi | mtlo), combinational.
- start while busy is ignored (stall_req holds it in ID/EX until the unit is idle).
- Divide by zero: no trap. LO=all ones, HI=rs_val (the original dividend). Still takes the full 33 cycles.
- Signed overflow 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- MTHI/MTLO: honoured only in IDLE with flush=0; register updates at the next edge; no done pulse. If start and mthi/mtlo are asserted together in IDLE, start wins and the write is dropped (the decoder never produces this case).
- flush: in CALC/FIX, go to IDLE at the next edge; HI/LO unchanged; no done. In IDLE, flush suppresses start/mthi/mtlo. Flush wins over every simultaneous event.
- hi/lo are direct register outputs, with no bypass of an in-flight result.

Decomposition:
- Shared package (cpu_types_pkg): typedef enum logic [1:0] muldiv_op_t {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU}.
- Local to the module: the state enum {MD_IDLE, MD_CALC, MD_FIX}.
- One natural sub-module, muldiv_step: a combinational single-iteration datapath.
  - Inputs: accumulator, operand, op.
  - Outputs: next accumulator and quotient bit.
  - The FSM, counter and HI/LO registers stay in muldiv_unit.

Test Plan:
- MULTU, rs=0xFFFFFFFF, rt=0xFFFFFFFF -> busy for 33 cycles; at E33 HI=0xFFFFFFFE, LO=0x00000001; done pulses exactly once.
- MULT, rs=0xFFFFFFFD (-3), rt=7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB (-21). DIV, rs=-7, rt=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU, rs=100, rt=0 -> LO=0xFFFFFFFF, HI=100 after 33 cycles. DIV, rs=0x80000000, rt=0xFFFFFFFF -> LO=0x80000000, HI=0.
- Start DIVU (rs=10, rt=3), assert hilo_read at cycle 5 -> stall_req=1 cycles 5..33; cycle 34 stall_req=0, LO=3, HI=1.
- Start MULT, assert flush at cycle 10 -> busy=0 at cycle 11, HI/LO keep their prior values (preloaded via MTHI=0x1234, MTLO=0x5678), no done.
- Assert nRST low at cycle 15 of a DIV -> hi=lo=0, busy=0 immediately (asynchronous, no clock edge needed); a new MULTU 2*3 afterwards gives LO=6, HI=0.
